// File: rtl/pll_reset_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding,
// default timing constants and the loss counter width.
package pll_reset_pkg;

   typedef enum logic [2:0] {
      WAIT_LOCK,
      QUALIFY,
      HOLD,
      STAGGER,
      RUN
   } state_t;

   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_LOCK_STABLE = 1024;
   localparam int DEF_HOLD_CYCLES = 16;
   localparam int DEF_STAGGER     = 8;
   localparam int DEF_LOSS_FILTER = 4;
   localparam int LOSS_COUNT_W    = 8;

   // Largest of the four timing parameters; sizes the shared counter width.
   function automatic int max_of(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/pll_reset_seq_sync_bit.sv
// Multi-stage single-bit synchroniser with asynchronous active-low clear.
// Output is the last stage of a STAGES-deep flop chain.
module sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   // Shift the asynchronous input through the flop chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ff <= '0;
      end else begin
         ff <= {ff[STAGES-2:0], d};
      end
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/pll_reset_seq.sv
// PLL lock qualifier and staggered reset sequencer for the 96 MHz domain.
// Qualifies a synchronised PLL lock, releases the core reset then the
// peripheral reset, and re-sequences on filtered lock loss or soft_rst.
// Optional build macro PLL_RESET_LOSS_COUNT_EN adds a saturating
// loss_count output.
module pll_reset_seq
   import pll_reset_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int LOCK_STABLE = DEF_LOCK_STABLE,
   parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
   parameter int STAGGER     = DEF_STAGGER,
   parameter int LOSS_FILTER = DEF_LOSS_FILTER
) (
   input  logic clk,
   input  logic rst_n,
   input  logic locked,
   input  logic soft_rst,
   input  logic clr_sticky,
   output logic rst_core_n,
   output logic rst_periph_n,
   output logic ready,
   output logic lock_lost
`ifdef PLL_RESET_LOSS_COUNT_EN
   ,
   output logic [LOSS_COUNT_W-1:0] loss_count
`endif
);

   localparam int CW = $clog2(max_of(LOCK_STABLE, HOLD_CYCLES, STAGGER, LOSS_FILTER) + 1);

   state_t        state;
   logic          locked_s;
   logic [CW-1:0] qual_cnt, hold_cnt, stag_cnt, loss_cnt;
   logic [CW-1:0] qual_inc, hold_inc, stag_inc;
   logic          in_seq;
   logic          loss_trip;

   sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (locked),
      .q     (locked_s)
   );

   assign qual_inc  = qual_cnt + CW'(1);
   assign hold_inc  = hold_cnt + CW'(1);
   assign stag_inc  = stag_cnt + CW'(1);
   assign in_seq    = (state == HOLD) || (state == pll_reset_pkg::STAGGER) || (state == RUN);
   // Trips on the cycle that would bring the low-run count to LOSS_FILTER.
   assign loss_trip = in_seq && !locked_s && (loss_cnt == CW'(LOSS_FILTER - 1));

   // Sequencer FSM; reset outputs are registered alongside each transition.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= WAIT_LOCK;
         qual_cnt     <= '0;
         hold_cnt     <= '0;
         stag_cnt     <= '0;
         loss_cnt     <= '0;
         rst_core_n   <= 1'b0;
         rst_periph_n <= 1'b0;
         ready        <= 1'b0;
         lock_lost    <= 1'b0;
      end else begin
         // Consecutive-low filter only runs once lock has been accepted.
         if (!in_seq || locked_s || loss_trip) begin
            loss_cnt <= '0;
         end else begin
            loss_cnt <= loss_cnt + CW'(1);
         end

         // A trip in the same cycle as clr_sticky leaves the flag set.
         if (loss_trip) begin
            lock_lost <= 1'b1;
         end else if (clr_sticky) begin
            lock_lost <= 1'b0;
         end

         if (loss_trip) begin
            state        <= WAIT_LOCK;
            rst_core_n   <= 1'b0;
            rst_periph_n <= 1'b0;
            ready        <= 1'b0;
         end else begin
            case (state)
               WAIT_LOCK: begin
                  if (locked_s) begin
                     if (LOCK_STABLE <= 1) begin
                        state    <= HOLD;
                        hold_cnt <= '0;
                     end else begin
                        state    <= QUALIFY;
                        qual_cnt <= CW'(1);
                     end
                  end
               end
               QUALIFY: begin
                  if (!locked_s) begin
                     state <= WAIT_LOCK;
                  end else if (qual_inc == CW'(LOCK_STABLE)) begin
                     state    <= HOLD;
                     qual_cnt <= qual_inc;
                     hold_cnt <= '0;
                  end else begin
                     qual_cnt <= qual_inc;
                  end
               end
               HOLD: begin
                  if (soft_rst) begin
                     hold_cnt <= '0;
                  end else if (hold_inc == CW'(HOLD_CYCLES)) begin
                     state      <= pll_reset_pkg::STAGGER;
                     hold_cnt   <= hold_inc;
                     stag_cnt   <= '0;
                     rst_core_n <= 1'b1;
                  end else begin
                     hold_cnt <= hold_inc;
                  end
               end
               pll_reset_pkg::STAGGER: begin
                  if (soft_rst) begin
                     state      <= HOLD;
                     hold_cnt   <= '0;
                     rst_core_n <= 1'b0;
                  end else if (stag_inc == CW'(STAGGER)) begin
                     state        <= RUN;
                     stag_cnt     <= stag_inc;
                     rst_periph_n <= 1'b1;
                     ready        <= 1'b1;
                  end else begin
                     stag_cnt <= stag_inc;
                  end
               end
               RUN: begin
                  if (soft_rst) begin
                     state        <= HOLD;
                     hold_cnt     <= '0;
                     rst_core_n   <= 1'b0;
                     rst_periph_n <= 1'b0;
                     ready        <= 1'b0;
                  end
               end
               default: begin
                  state        <= WAIT_LOCK;
                  rst_core_n   <= 1'b0;
                  rst_periph_n <= 1'b0;
                  ready        <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef PLL_RESET_LOSS_COUNT_EN
   // Saturating count of loss-filter trips; only rst_n clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         loss_count <= '0;
      end else if (loss_trip && (loss_count != {LOSS_COUNT_W{1'b1}})) begin
         loss_count <= loss_count + LOSS_COUNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Self-checking bench for pll_reset_seq: a fixed vector table, hand-written
// latency / async-reset sequences and a randomized run against a
// behavioural model. Build with PLL_RESET_LOSS_COUNT_EN to cover loss_count.
module tb_pll_reset_seq;

   localparam int SS = 2;
   localparam int LS = 8;
   localparam int HC = 4;
   localparam int ST = 3;
   localparam int LF = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic locked = 1'b0;
   logic soft_rst = 1'b0;
   logic clr_sticky = 1'b0;
   logic rst_core_n, rst_periph_n, ready, lock_lost;
`ifdef PLL_RESET_LOSS_COUNT_EN
   logic [7:0] loss_count;
`endif

   pll_reset_seq #(
      .SYNC_STAGES (SS),
      .LOCK_STABLE (LS),
      .HOLD_CYCLES (HC),
      .STAGGER     (ST),
      .LOSS_FILTER (LF)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .locked       (locked),
      .soft_rst     (soft_rst),
      .clr_sticky   (clr_sticky),
      .rst_core_n   (rst_core_n),
      .rst_periph_n (rst_periph_n),
      .ready        (ready),
      .lock_lost    (lock_lost)
`ifdef PLL_RESET_LOSS_COUNT_EN
      ,
      .loss_count   (loss_count)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int edge_no = 0;

   // Behavioural model: lock accepted after LS consecutive synchronised highs;
   // m_seq counts cycles since (re)start of the hold phase.
   bit m_syn [SS];
   bit m_armed, m_lost;
   int m_hi, m_lo, m_seq, m_lcnt;

   function automatic bit m_core();
      return m_armed && (m_seq >= HC);
   endfunction
   function automatic bit m_periph();
      return m_armed && (m_seq >= HC + ST);
   endfunction

   task automatic m_reset();
      for (int i = 0; i < SS; i++) m_syn[i] = 1'b0;
      m_armed = 0; m_lost = 0; m_hi = 0; m_lo = 0; m_seq = 0; m_lcnt = 0;
   endtask

   task automatic m_step(input bit lk, input bit sf, input bit cl);
      bit ls, trip;
      ls = m_syn[SS-1];
      for (int i = SS - 1; i > 0; i--) m_syn[i] = m_syn[i-1];
      m_syn[0] = lk;
      trip = 0;
      if (!m_armed) begin
         m_hi = ls ? m_hi + 1 : 0;
         if (m_hi >= LS) begin
            m_armed = 1; m_seq = 0; m_lo = 0;
         end
      end else begin
         m_lo = ls ? 0 : m_lo + 1;
         if (m_lo >= LF) begin
            trip = 1; m_armed = 0; m_hi = 0; m_lo = 0;
         end else if (sf) begin
            m_seq = 0;
         end else if (m_seq < HC + ST) begin
            m_seq++;
         end
      end
      if (trip) begin
         m_lost = 1;
         if (m_lcnt < 255) m_lcnt++;
      end else if (cl) begin
         m_lost = 0;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at edge %0d: actual=%0d required=%0d", name, edge_no, act, exp);
      end
   endtask

   task automatic check_rng(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         failures++;
         $display("FAIL %s: actual=%0d required=%0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic compare_model();
      check("core_vs_model", rst_core_n, m_core());
      check("periph_vs_model", rst_periph_n, m_periph());
      check("ready_vs_model", ready, m_periph());
      check("lost_vs_model", lock_lost, m_lost);
`ifdef PLL_RESET_LOSS_COUNT_EN
      check("losscnt_vs_model", loss_count, m_lcnt);
`endif
   endtask

   // Drive inputs for the next edge, advance the model, compare after the edge.
   task automatic step(input bit lk, input bit sf, input bit cl);
      locked = lk; soft_rst = sf; clr_sticky = cl;
      @(posedge clk);
      m_step(lk, sf, cl);
      edge_no++;
      #1;
      compare_model();
   endtask

   task automatic do_reset();
      rst_n = 1'b0; locked = 1'b0; soft_rst = 1'b0; clr_sticky = 1'b0;
      #1;
      check("rst_core", rst_core_n, 0);
      check("rst_periph", rst_periph_n, 0);
      check("rst_ready", ready, 0);
      check("rst_lost", lock_lost, 0);
`ifdef PLL_RESET_LOSS_COUNT_EN
      check("rst_losscnt", loss_count, 0);
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      m_reset();
      edge_no = 0;
   endtask

   typedef struct {
      bit lk; bit sf; bit cl; int n;
      bit core; bit per; bit rdy; bit lost;
   } vec_t;

   vec_t tbl [25];

   initial begin
      int core_e, per_e, rdy_e, burst;
      bit lk;

      tbl[0]  = '{1,0,0,5, 0,0,0,0};
      tbl[1]  = '{0,0,0,1, 0,0,0,0};
      tbl[2]  = '{1,0,0,8, 0,0,0,0};
      tbl[3]  = '{1,0,0,2, 0,0,0,0};
      tbl[4]  = '{1,0,0,4, 1,0,0,0};
      tbl[5]  = '{1,0,0,2, 1,0,0,0};
      tbl[6]  = '{1,0,0,1, 1,1,1,0};
      tbl[7]  = '{0,0,0,1, 1,1,1,0};
      tbl[8]  = '{1,0,0,3, 1,1,1,0};
      tbl[9]  = '{0,0,0,2, 1,1,1,0};
      tbl[10] = '{1,0,1,2, 0,0,0,1};
      tbl[11] = '{1,0,1,1, 0,0,0,0};
      tbl[12] = '{1,1,0,3, 0,0,0,0};
      tbl[13] = '{1,0,0,4, 0,0,0,0};
      tbl[14] = '{1,0,0,4, 1,0,0,0};
      tbl[15] = '{1,0,0,3, 1,1,1,0};
      tbl[16] = '{1,1,0,1, 0,0,0,0};
      tbl[17] = '{1,0,0,3, 0,0,0,0};
      tbl[18] = '{1,0,0,1, 1,0,0,0};
      tbl[19] = '{1,0,0,3, 1,1,1,0};
      tbl[20] = '{1,1,0,1, 0,0,0,0};
      tbl[21] = '{1,0,0,2, 0,0,0,0};
      tbl[22] = '{1,1,0,1, 0,0,0,0};
      tbl[23] = '{1,0,0,3, 0,0,0,0};
      tbl[24] = '{1,0,0,1, 1,0,0,0};

      #1;
      do_reset();

      // Vector table: unstable lock, stagger timing, glitch, sticky, soft_rst.
      for (int i = 0; i < 25; i++) begin
         repeat (tbl[i].n) step(tbl[i].lk, tbl[i].sf, tbl[i].cl);
         check($sformatf("tbl%0d_core", i), rst_core_n, tbl[i].core);
         check($sformatf("tbl%0d_periph", i), rst_periph_n, tbl[i].per);
         check($sformatf("tbl%0d_ready", i), ready, tbl[i].rdy);
         check($sformatf("tbl%0d_lost", i), lock_lost, tbl[i].lost);
      end

      // Clean lock latency: locked rises just after edge 10.
      do_reset();
      core_e = -1; per_e = -1; rdy_e = -1;
      for (int k = 0; k < 60; k++) begin
         step(edge_no >= 10, 0, 0);
         if (core_e < 0 && rst_core_n === 1'b1) core_e = edge_no;
         if (per_e < 0 && rst_periph_n === 1'b1) per_e = edge_no;
         if (rdy_e < 0 && ready === 1'b1) rdy_e = edge_no;
      end
      check_rng("lat_core", core_e, 10 + SS + LS + HC + 1 - 1, 10 + SS + LS + HC + 1 + 1);
      check("lat_periph_gap", per_e - core_e, ST);
      check("lat_ready_edge", rdy_e, per_e);

      // Async reset in STAGGER drops rst_core_n without a clock edge.
      do_reset();
      for (int k = 0; k < 40; k++) begin
         step(1, 0, 0);
         if (rst_core_n === 1'b1) break;
      end
      step(1, 0, 0);
      check("pre_async_core", rst_core_n, 1);
      rst_n = 1'b0;
      #2;
      check("async_core", rst_core_n, 0);
      check("async_periph", rst_periph_n, 0);
      do_reset();

      // Randomized run against the model.
      burst = 0;
      for (int k = 0; k < 3000; k++) begin
         if (burst > 0) begin
            lk = 0; burst--;
         end else if ($urandom_range(0, 99) < 6) begin
            lk = 0; burst = $urandom_range(0, 2);
         end else begin
            lk = 1;
         end
         step(lk, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 5);
      end

`ifdef PLL_RESET_LOSS_COUNT_EN
      // 300 forced losses saturate the counter; clr_sticky leaves it alone.
      do_reset();
      for (int k = 0; k < 300; k++) begin
         repeat (12) step(1, 0, 0);
         repeat (4) step(0, 0, 1);
      end
      check("losscnt_sat", loss_count, 255);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Watchdog so the run always terminates.
   initial begin
      #2000000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
